// File: rtl/fifo_rd_packer.sv
// Read-side width upsizer behind the dual-clock FIFO: packs PACK_RATIO FWFT entries per
// output word and closes partial words on flush or when the FIFO starves for TIMEOUT cycles.

module fifo_rd_packer_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  load,
  input  logic                  used,
  output logic [DATA_WIDTH-1:0] out_lane
);
  logic [DATA_WIDTH-1:0] acc;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      acc      <= '0;
      out_lane <= '0;
    end else begin
      if (wr_en) acc <= wr_data;
      // Lanes beyond the fill level go out as zero, not as stale data.
      if (load) out_lane <= used ? acc : '0;
    end
  end
endmodule

module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  input  logic                             fifo_rd_empty,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready
);
  localparam int CW = $clog2(PACK_RATIO + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {EMPTY, FILL, CLOSED} state_t;

  state_t                               state;
  logic [CW-1:0]                        cnt, cnt_wr, cnt_pop;
  logic [TW-1:0]                        tcnt;
  logic                                 last_q, free, xfer, pop, starved, tmo;
  logic [PACK_RATIO-1:0]                used;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] out_lanes;

  assign free       = ~out_valid | out_ready;
  assign xfer       = (state == CLOSED) & free;
  assign pop        = rd_rst_n & ~fifo_rd_empty & ((state != CLOSED) | xfer);
  assign fifo_rd_en = pop;
  // A pop in the hand-off cycle lands in lane 0 of the freshly emptied accumulator.
  assign cnt_wr     = xfer ? '0 : cnt;
  assign cnt_pop    = cnt + CW'(pop);
  assign starved    = (state == FILL) & fifo_rd_empty & ~flush;
  assign tmo        = (TIMEOUT > 0) && starved && (tcnt == TW'(TIMEOUT - 1));

  for (genvar i = 0; i < PACK_RATIO; i++) begin : g_lane
    assign used[i] = CW'(i) < cnt;
    fifo_rd_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .rd_clk   (rd_clk),
      .rd_rst_n (rd_rst_n),
      .wr_en    (pop && (cnt_wr == CW'(i))),
      .wr_data  (fifo_rd_data),
      .load     (xfer),
      .used     (used[i]),
      .out_lane (out_lanes[i])
    );
  end

  assign out_data = out_lanes;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state     <= EMPTY;
      cnt       <= '0;
      tcnt      <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_keep  <= used;
        out_last  <= last_q | flush;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      tcnt <= '0;
      case (state)
        EMPTY: if (pop) begin
          state <= FILL;
          cnt   <= CW'(1);
        end
        FILL: begin
          cnt <= cnt_pop;
          if (cnt_pop == CW'(PACK_RATIO)) begin
            state  <= CLOSED;
            last_q <= flush;
          end else if (flush || tmo) begin
            state  <= CLOSED;
            last_q <= 1'b1;
          end else if (starved && (TIMEOUT > 0)) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CLOSED: begin
          if (xfer) begin
            last_q <= 1'b0;
            state  <= pop ? FILL : EMPTY;
            cnt    <= pop ? CW'(1) : '0;
          end else if (flush) begin
            last_q <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue models the FIFO, expected words are queued
// with the stimulus and compared on every accepted output word.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PR = 4;
  localparam int TO = 15;

  typedef struct packed {
    logic [DW*PR-1:0] data;
    logic [PR-1:0]    keep;
    logic             last;
  } word_t;

  logic             rd_clk = 1'b0;
  logic             rd_rst_n = 1'b0;
  logic [DW-1:0]    fifo_rd_data = '0;
  logic             fifo_rd_empty = 1'b1;
  logic             fifo_rd_en;
  logic             flush = 1'b0;
  logic [DW*PR-1:0] out_data;
  logic [PR-1:0]    out_keep;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b0;

  logic [DW-1:0] fifo_q[$];
  word_t         exp_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  logic          pop_seen = 1'b0;
  logic          vld_seen = 1'b0;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT(TO)) dut (
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_en    (fifo_rd_en),
    .flush         (flush),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [DW*PR-1:0] d, input logic [PR-1:0] k, input logic l);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    exp_q.push_back(w);
  endtask

  // One clock: present FIFO head, sample away from the edge, then retire the pop.
  task automatic step();
    word_t e;
    fifo_rd_empty = (fifo_q.size() == 0);
    fifo_rd_data  = fifo_rd_empty ? '0 : fifo_q[0];
    #1;
    pop_seen = fifo_rd_en;
    vld_seen = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 64'(out_data), 64'(e.data));
        chk("word_keep", 64'(out_keep), 64'(e.keep));
        chk("word_last", 64'(out_last), 64'(e.last));
      end
    end
    @(posedge rd_clk);
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    @(negedge rd_clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cnt;
    int first;

    // Reset held with a non-empty FIFO
    fifo_q.push_back(8'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rd_en", 64'(pop_seen), 64'd0);
    end
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_keep",  64'(out_keep),  64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    fifo_q.delete();
    rd_rst_n = 1'b1;
    steps(2);

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
    exp_push(32'h04030201, 4'hF, 1'b0);
    exp_push(32'h08070605, 4'hF, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnt += int'(pop_seen);
    end
    chk("strm_rd_en_run", 64'(cnt), 64'd8);
    steps(6);
    chk("strm_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) fifo_q.push_back(DW'(i));
    exp_push(32'h04030201, 4'hF, 1'b0);
    exp_push(32'h08070605, 4'hF, 1'b0);
    exp_push(32'h0C0B0A09, 4'hF, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt += int'(pop_seen);
    end
    chk("bp_pops",  64'(cnt), 64'd8);
    chk("bp_rd_en", 64'(pop_seen), 64'd0);
    chk("bp_valid", 64'(vld_seen), 64'd1);
    chk("bp_hold",  64'(out_data), 64'h04030201);
    out_ready = 1'b1;
    steps(20);
    chk("bp_drain", 64'(exp_q.size()), 64'd0);
    chk("bp_fifo_empty", 64'(fifo_q.size()), 64'd0);

    // Timeout: two entries then starvation
    fifo_q.push_back(8'hAA);
    fifo_q.push_back(8'hBB);
    exp_push(32'h0000BBAA, 4'h3, 1'b1);
    steps(2);
    first = 0;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (vld_seen && first == 0) first = j;
    end
    chk("tmo_latency", 64'(first), 64'd17);
    chk("tmo_drain", 64'(exp_q.size()), 64'd0);

    // Flush together with a pop
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    steps(2);
    fifo_q.push_back(8'h33);
    exp_push(32'h00332211, 4'h7, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    steps(5);
    chk("flush_drain", 64'(exp_q.size()), 64'd0);

    // Flush while EMPTY produces nothing
    flush = 1'b1;
    step();
    flush = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(vld_seen);
    end
    chk("empty_flush_valid", 64'(cnt), 64'd0);

    // Reset with a stalled word and a partial accumulator
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) fifo_q.push_back(DW'(i));
    steps(7);
    chk("mr_pre_valid", 64'(vld_seen), 64'd1);
    rd_rst_n = 1'b0;
    step();
    rd_rst_n = 1'b1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_keep",  64'(out_keep),  64'd0);
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h21 + i));
    exp_push(32'h24232221, 4'hF, 1'b0);
    out_ready = 1'b1;
    steps(10);
    chk("mr_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
